capture_control: RTL and testbench

Capture sequencer between the trigger unit and the host readout path. It writes every valid sample into a circular sample RAM and arms the trigger once the requested pre-trigger history is buffered. It then records a fixed number of post-trigger samples and streams the captured window, oldest first, over a ready/valid interface. It drives the trigger unit's `arm` input and consumes its `run` output.

---
 rtl/capture_control.sv | 256 +++++++++++++++++++++++++
 tb/tb_capture_control.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/capture_control.sv
// -----------------------------------------------------------------------------
// capture_control
//
// Capture sequencer between the trigger unit and the host readout path.
// Every valid sample is written into a circular sample RAM. Once the requested
// pre-trigger history is buffered, the trigger unit is armed. After the
// trigger, a fixed number of post-trigger samples is recorded. The captured
// window is then streamed out, oldest word first, over a ready/valid
// interface.
//
// Parameters
//   SAMPLE_WIDTH  bits per sample word
//   ADDR_WIDTH    RAM address width, depth D = 2**ADDR_WIDTH
//
// Ports
//   clock         sole clock, rising edge
//   reset_n       asynchronous active-low reset
//   valid/dataIn  sample strobe and sample word
//   run           trigger-fired indication from the trigger unit
//   start         one-cycle capture request, honoured only in IDLE
//   abort         cancels any activity, highest priority
//   pre_count     pre-trigger sample count P, latched on accepted start
//   post_count    post-trigger sample count including the trigger sample
//   arm           one-cycle pulse to the trigger unit on entering WAIT_TRIG
//   busy          high in every state except IDLE
//   capture_done  high throughout READ
//   rd_ready      consumer ready
//   rd_valid      rd_data holds a captured word
//   rd_data       captured word
//   rd_last       marks the final word of the window
//   wait_count    valid samples seen in WAIT_TRIG
//
// Build option
//   CAPTURE_CONTROL_WAITCNT_EN  when defined, wait_count is a saturating
//   32-bit counter; otherwise it is tied to zero.
// -----------------------------------------------------------------------------
module capture_control #(
  parameter int SAMPLE_WIDTH = 8,
  parameter int ADDR_WIDTH   = 10
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    valid,
  input  logic [SAMPLE_WIDTH-1:0] dataIn,
  input  logic                    run,
  input  logic                    start,
  input  logic                    abort,
  input  logic [ADDR_WIDTH-1:0]   pre_count,
  input  logic [ADDR_WIDTH:0]     post_count,
  output logic                    arm,
  output logic                    busy,
  output logic                    capture_done,
  input  logic                    rd_ready,
  output logic                    rd_valid,
  output logic [SAMPLE_WIDTH-1:0] rd_data,
  output logic                    rd_last,
  output logic [31:0]             wait_count
);

  localparam int D  = 1 << ADDR_WIDTH;
  localparam int CW = ADDR_WIDTH + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREFILL,
    S_WAIT_TRIG,
    S_POST,
    S_READ
  } state_t;

  state_t state, state_nxt;

  logic [SAMPLE_WIDTH-1:0] mem [D];

  logic [ADDR_WIDTH-1:0] wp;
  logic [ADDR_WIDTH-1:0] p_len;
  logic [ADDR_WIDTH-1:0] fill_cnt;
  logic [ADDR_WIDTH-1:0] trig_addr;
  logic [ADDR_WIDTH-1:0] ra;
  logic [ADDR_WIDTH-1:0] rd_base;
  logic [CW-1:0]         n_len;
  logic [CW-1:0]         post_cnt;
  logic [CW-1:0]         rd_left;

  logic                    ram_vld_p1;
  logic                    ram_last_p1;
  logic [SAMPLE_WIDTH-1:0] ram_data_p1;
  logic                    skid_vld_p2;
  logic                    skid_last_p2;
  logic [SAMPLE_WIDTH-1:0] skid_data_p2;

  logic start_ok, we, trig_hit, fill_done, post_done, rd_done;
  logic out_load, issue, skid_fill, enter_read;

  // N = max(post, 1), limited so that the window P + N never exceeds the RAM.
  function automatic logic [CW-1:0] clamp_post(input logic [CW-1:0]         post,
                                               input logic [ADDR_WIDTH-1:0] pre);
    logic [CW-1:0] n;
    logic [CW-1:0] room;
    n    = (post == '0) ? CW'(1) : post;
    room = CW'(D) - CW'(pre);
    return (n > room) ? room : n;
  endfunction

  assign start_ok  = start && !abort && (state == S_IDLE);
  assign we        = valid && !abort &&
                     ((state == S_PREFILL) || (state == S_WAIT_TRIG) || (state == S_POST));
  assign trig_hit  = (state == S_WAIT_TRIG) && valid && run && !abort;
  assign fill_done = (state == S_PREFILL) && we &&
                     ((CW'(fill_cnt) + CW'(1)) == CW'(p_len));
  assign post_done = (state == S_POST) && we && ((post_cnt + CW'(1)) == n_len);
  assign rd_done   = (state == S_READ) && rd_valid && rd_ready && rd_last;

  assign busy         = (state != S_IDLE);
  assign capture_done = (state == S_READ);

  // The trigger sample can also be the last post sample (N == 1); the window
  // base must then come from the live write pointer, not trig_addr.
  assign rd_base    = (trig_hit ? wp : trig_addr) - p_len;
  assign enter_read = (state_nxt == S_READ) && (state != S_READ);

  // Output register accepts a new word when empty or being consumed.
  assign out_load  = !rd_valid || rd_ready;
  // Issue a read only when its result is guaranteed a slot one cycle later:
  // either the output drains this cycle or nothing is queued behind it.
  assign issue     = (state == S_READ) && !abort && (rd_left != '0) &&
                     (out_load || (!skid_vld_p2 && !ram_vld_p1));
  assign skid_fill = ram_vld_p1 && !out_load;

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:      if (start) state_nxt = (pre_count == '0) ? S_WAIT_TRIG : S_PREFILL;
        S_PREFILL:   if (fill_done) state_nxt = S_WAIT_TRIG;
        S_WAIT_TRIG: if (trig_hit) state_nxt = (n_len == CW'(1)) ? S_READ : S_POST;
        S_POST:      if (post_done) state_nxt = S_READ;
        S_READ:      if (rd_done) state_nxt = S_IDLE;
        default:     state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      arm       <= 1'b0;
      wp        <= '0;
      p_len     <= '0;
      n_len     <= '0;
      fill_cnt  <= '0;
      post_cnt  <= '0;
      trig_addr <= '0;
    end else begin
      state <= state_nxt;
      arm   <= (state_nxt == S_WAIT_TRIG) && (state != S_WAIT_TRIG);
      if (start_ok) begin
        p_len    <= pre_count;
        n_len    <= clamp_post(post_count, pre_count);
        wp       <= '0;
        fill_cnt <= '0;
        post_cnt <= '0;
      end else if (we) begin
        wp <= wp + 1'b1;
        if (state == S_PREFILL) fill_cnt <= fill_cnt + 1'b1;
        if (trig_hit) begin
          trig_addr <= wp;
          post_cnt  <= CW'(1);
        end else if (state == S_POST) begin
          post_cnt <= post_cnt + CW'(1);
        end
      end
    end
  end

  // ---- stage p0: read address / remaining-word counter ----
  // ---- stage p1: synchronous RAM output ----
  // ---- stage p2: skid register, then the rd_* output register ----
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ra           <= '0;
      rd_left      <= '0;
      ram_vld_p1   <= 1'b0;
      ram_last_p1  <= 1'b0;
      skid_vld_p2  <= 1'b0;
      skid_last_p2 <= 1'b0;
      rd_valid     <= 1'b0;
      rd_last      <= 1'b0;
      rd_data      <= '0;
    end else if (state_nxt != S_READ) begin
      ram_vld_p1  <= 1'b0;
      skid_vld_p2 <= 1'b0;
      rd_valid    <= 1'b0;
      rd_last     <= 1'b0;
      rd_left     <= '0;
    end else if (enter_read) begin
      ra          <= rd_base;
      rd_left     <= CW'(p_len) + n_len;
      ram_vld_p1  <= 1'b0;
      skid_vld_p2 <= 1'b0;
      rd_valid    <= 1'b0;
    end else begin
      ram_vld_p1 <= issue;
      if (issue) begin
        ra          <= ra + 1'b1;
        rd_left     <= rd_left - CW'(1);
        ram_last_p1 <= (rd_left == CW'(1));
      end
      if (out_load) begin
        if (skid_vld_p2) begin
          rd_valid    <= 1'b1;
          rd_last     <= skid_last_p2;
          rd_data     <= skid_data_p2;
          skid_vld_p2 <= 1'b0;
        end else if (ram_vld_p1) begin
          rd_valid <= 1'b1;
          rd_last  <= ram_last_p1;
          rd_data  <= ram_data_p1;
        end else begin
          rd_valid <= 1'b0;
        end
      end else if (ram_vld_p1) begin
        skid_vld_p2  <= 1'b1;
        skid_last_p2 <= ram_last_p1;
      end
    end
  end

  // Sample storage and read data path; contents are never reset.
  always_ff @(posedge clock) begin
    if (we) mem[wp] <= dataIn;
    ram_data_p1 <= mem[ra];
    if (skid_fill) skid_data_p2 <= ram_data_p1;
  end

`ifdef CAPTURE_CONTROL_WAITCNT_EN
  logic [31:0] wait_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
    end else if (start_ok) begin
      wait_cnt <= '0;
    end else if ((state == S_WAIT_TRIG) && valid && !abort && (wait_cnt != '1)) begin
      wait_cnt <= wait_cnt + 32'd1;
    end
  end

  assign wait_count = wait_cnt;
`else
  assign wait_count = '0;
`endif

endmodule

// File: tb/tb_capture_control.sv
module tb_capture_control;
  localparam int SW = 8;
  localparam int AW = 3;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          valid, run, start, abort, rd_ready;
  logic [SW-1:0] dataIn;
  logic [AW-1:0] pre_count;
  logic [AW:0]   post_count;
  logic          arm, busy, capture_done, rd_valid, rd_last;
  logic [SW-1:0] rd_data;
  logic [31:0]   wait_count;

  capture_control #(.SAMPLE_WIDTH(SW), .ADDR_WIDTH(AW)) dut (
    .clock(clock), .reset_n(reset_n), .valid(valid), .dataIn(dataIn), .run(run),
    .start(start), .abort(abort), .pre_count(pre_count), .post_count(post_count),
    .arm(arm), .busy(busy), .capture_done(capture_done), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last), .wait_count(wait_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [SW-1:0] d;
    logic          l;
  } word_t;

  typedef struct {
    int       p;
    int       post;
    int       trig;
    int       period;
    logic [3:0] ready_pat;
    int       base;
    bit       sparse_run;
    bit       spurious_start;
    int       first;
    int       len;
    int       exp_wait;
  } case_t;

  case_t tbl[8];
  word_t exp_q[$];
  word_t mon_w;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wr_count = 0;
  int arm_seen = 0;
  int exp_arm_at = 0;
  int first_x = -1;
  int last_x = -1;
  logic          stall_prev = 1'b0;
  logic [SW-1:0] held_d;
  logic          held_l;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  always @(posedge clock) cyc++;

  // Output monitor: scoreboard pop, hold-stability and arm timing.
  always @(negedge clock) begin
    if (reset_n) begin
      if (stall_prev) begin
        check("hold_valid", rd_valid, 1);
        check("hold_data", rd_data, held_d);
        check("hold_last", rd_last, held_l);
      end
      if (rd_valid && rd_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %0d, expected no transfer", rd_data);
        end else begin
          mon_w = exp_q.pop_front();
          check("rd_data", rd_data, mon_w.d);
          check("rd_last", rd_last, mon_w.l);
          if (first_x < 0) first_x = cyc;
          last_x = cyc;
        end
      end
      if (rd_valid) check("capture_done_in_read", capture_done, 1);
      if (arm) begin
        arm_seen++;
        check("arm_timing", wr_count, exp_arm_at);
      end
      stall_prev = rd_valid && !rd_ready;
      held_d     = rd_data;
      held_l     = rd_last;
    end else begin
      stall_prev = 1'b0;
    end
  end

  // Issue start, then feed samples 0..nlast; data = base + index.
  task automatic feed(input int p, input int post, input int trig, input int nlast,
                      input int period, input int base, input bit sparse, input bit spur);
    int i;
    int k;
    wr_count   = 0;
    arm_seen   = 0;
    exp_arm_at = p;
    first_x    = -1;
    last_x     = -1;
    rd_ready   = 1'b0;
    start      = 1'b1;
    pre_count  = AW'(p);
    post_count = (AW+1)'(post);
    @(posedge clock); #1;
    start = 1'b0;
    check("busy_on_start", busy, 1);
    i = 0;
    k = 0;
    while (i <= nlast) begin
      valid  = ((k % period) == period - 1);
      dataIn = 8'(base + i);
      if (sparse) run = valid ? ((i < p) || (i >= trig)) : 1'b1;
      else        run = valid && (i == trig);
      start = spur && valid && (i == p + 1);
      if (start) begin
        pre_count  = 1;
        post_count = 1;
      end
      @(posedge clock);
      if (valid) begin
        wr_count++;
        i++;
      end
      #1;
      k++;
    end
    valid = 1'b0;
    run   = 1'b0;
    start = 1'b0;
  endtask

  task automatic run_case(input case_t c);
    int k;
    word_t w;
    exp_q.delete();
    for (int j = 0; j < c.len; j++) begin
      w.d = 8'(c.first + j);
      w.l = (j == c.len - 1);
      exp_q.push_back(w);
    end
    feed(c.p, c.post, c.trig, c.trig + c.len - c.p - 1, c.period, c.base,
         c.sparse_run, c.spurious_start);
    k = 0;
    while (!capture_done && k < 20) begin
      @(posedge clock); #1;
      k++;
    end
    check("capture_done_rise", capture_done, 1);
    k = 0;
    while (!rd_valid && k < 5) begin
      @(posedge clock); #1;
      k++;
    end
    check("first_rd_valid_within_2", (k <= 2), 1);
    k = 0;
    while (exp_q.size() > 0 && k < 200) begin
      rd_ready = c.ready_pat[3 - (k % 4)];
      @(posedge clock); #1;
      k++;
    end
    rd_ready = 1'b0;
    check("readout_complete", exp_q.size(), 0);
    exp_q.delete();
    check("busy_after_last", busy, 0);
    check("capture_done_after_last", capture_done, 0);
    check("rd_valid_after_last", rd_valid, 0);
    check("arm_pulses", arm_seen, 1);
    if (c.ready_pat == 4'b1111) check("no_bubbles", last_x - first_x + 1, c.len);
`ifdef CAPTURE_CONTROL_WAITCNT_EN
    check("wait_count", wait_count, c.exp_wait);
`else
    check("wait_count", wait_count, 0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    //          p post trig per ready    base  sparse spur first len wait
    tbl[0] = '{4, 4,  10,  1, 4'b1111, 8'h00, 1'b0, 1'b1, 6,    8,  7};
    tbl[1] = '{3, 5,  20,  1, 4'b1111, 8'h00, 1'b0, 1'b0, 17,   8,  18};
    tbl[2] = '{4, 4,  10,  1, 4'b1001, 8'h40, 1'b0, 1'b0, 8'h46, 8, 7};
    tbl[3] = '{2, 3,  5,   3, 4'b1111, 8'h80, 1'b1, 1'b0, 8'h83, 5, 4};
    tbl[4] = '{6, 10, 9,   1, 4'b1111, 8'h20, 1'b0, 1'b0, 8'h23, 8, 4};
    tbl[5] = '{0, 3,  0,   1, 4'b0101, 8'h10, 1'b0, 1'b0, 8'h10, 3, 1};
    tbl[6] = '{3, 0,  5,   1, 4'b1111, 8'h30, 1'b0, 1'b0, 8'h32, 4, 3};
    tbl[7] = '{7, 1,  7,   1, 4'b1111, 8'h50, 1'b0, 1'b0, 8'h50, 8, 1};

    reset_n    = 1'b0;
    valid      = 1'b0;
    run        = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    rd_ready   = 1'b0;
    dataIn     = '0;
    pre_count  = '0;
    post_count = '0;
    repeat (2) @(posedge clock);
    #1;
    check("reset_busy", busy, 0);
    check("reset_arm", arm, 0);
    check("reset_capture_done", capture_done, 0);
    check("reset_rd_valid", rd_valid, 0);
    check("reset_rd_data", rd_data, 0);
    check("reset_rd_last", rd_last, 0);
    check("reset_wait_count", wait_count, 0);
    reset_n = 1'b1;
    @(posedge clock); #1;

    // start together with abort: abort wins, stays IDLE
    start = 1'b1;
    abort = 1'b1;
    pre_count = 3'd2;
    post_count = 4'd2;
    @(posedge clock); #1;
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_busy", busy, 0);

    for (int n = 0; n < 8; n++) run_case(tbl[n]);

    // abort mid-POST: back to IDLE at once, no readout
    exp_q.delete();
    feed(2, 6, 3, 5, 1, 8'h60, 1'b0, 1'b0);
    check("post_state_busy", busy, 1);
    abort  = 1'b1;
    valid  = 1'b1;
    dataIn = 8'h66;
    @(posedge clock); #1;
    abort = 1'b0;
    valid = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_capture_done", capture_done, 0);
    check("abort_rd_valid", rd_valid, 0);
    check("abort_arm_pulses", arm_seen, 1);
    rd_ready = 1'b1;
    repeat (10) @(posedge clock);
    #1;
    rd_ready = 1'b0;
    check("abort_no_readout", rd_valid, 0);
    check("abort_stays_idle", busy, 0);

    // asynchronous reset in the middle of READ
    feed(2, 2, 3, 4, 1, 8'h70, 1'b0, 1'b0);
    for (int k = 0; k < 6 && !rd_valid; k++) begin
      @(posedge clock); #1;
    end
    check("pre_reset_rd_valid", rd_valid, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_rd_valid", rd_valid, 0);
    check("async_reset_busy", busy, 0);
    check("async_reset_capture_done", capture_done, 0);
    check("async_reset_rd_data", rd_data, 0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;

    // normal operation after reset
    run_case(tbl[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
